// File: rtl/rv_iopmp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv_iopmp_pkg
// Purpose : Shared types, constants and helpers for the IOPMP hardware-update
//           write arbiter (rv_iopmp_hw_wr_arb) and its round-robin core.
// Contents: RV_IOPMP_AW / RV_IOPMP_DW  default register index / data widths
//           CONFLICT_CNT_W             width of the deferral counter
//           hw_upd_t                   {addr, data} hardware update record
//           sat_inc()                  saturating increment for the counter
// Revision: 1.0 - initial release
// ============================================================================
package rv_iopmp_pkg;

   localparam int unsigned RV_IOPMP_AW    = 6;
   localparam int unsigned RV_IOPMP_DW    = 32;
   localparam int unsigned CONFLICT_CNT_W = 8;

   typedef struct packed {
      logic [RV_IOPMP_AW-1:0] addr;
      logic [RV_IOPMP_DW-1:0] data;
   } hw_upd_t;

   // Holds at all-ones instead of wrapping back to zero.
   function automatic logic [CONFLICT_CNT_W-1:0] sat_inc(
      input logic [CONFLICT_CNT_W-1:0] v
   );
      logic [CONFLICT_CNT_W-1:0] r;
      r = (&v) ? v : (v + 1'b1);
      return r;
   endfunction

endpackage : rv_iopmp_pkg
`default_nettype wire

// File: rtl/rv_iopmp_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : rv_iopmp_rr_arb
// Purpose : Purely combinational round-robin grant selection. The grant goes
//           to the first asserted request at or after rr_ptr_i, wrapping
//           modulo NReq.
// Ports   : req_i      [NReq]  request vector
//           rr_ptr_i   [IdxW]  highest-priority index this cycle
//           gnt_o      [NReq]  one-hot grant (zero when no request)
//           gnt_idx_o  [IdxW]  binary index of the granted requester
//           any_gnt_o  [1]     some request is granted
// Revision: 1.0 - initial release
// ============================================================================
module rv_iopmp_rr_arb #(
   parameter int unsigned NReq = 4,
   parameter int unsigned IdxW = (NReq > 1) ? $clog2(NReq) : 1
) (
   input  logic [NReq-1:0] req_i,
   input  logic [IdxW-1:0] rr_ptr_i,
   output logic [NReq-1:0] gnt_o,
   output logic [IdxW-1:0] gnt_idx_o,
   output logic            any_gnt_o
);

   // Scan offsets from the farthest to the nearest so the last hit written
   // is the one closest to rr_ptr_i, i.e. the highest-priority request.
   always_comb begin
      int idx;
      gnt_o     = '0;
      gnt_idx_o = '0;
      any_gnt_o = 1'b0;
      idx       = 0;
      for (int k = int'(NReq) - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_i) + k) % int'(NReq);
         if (req_i[idx]) begin
            gnt_o      = '0;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = IdxW'(idx);
            any_gnt_o  = 1'b1;
         end
      end
   end

endmodule : rv_iopmp_rr_arb
`default_nettype wire

// File: rtl/rv_iopmp_hw_wr_arb.sv
`default_nettype none
// ============================================================================
// Module  : rv_iopmp_hw_wr_arb
// Purpose : Shares the hardware-update port (de/d) of the IOPMP register
//           slice bank between NReq hardware requesters. Round-robin
//           arbitration, valid/ready handshake, one-deep output stage.
//           A software write to the same register index defers the staged
//           update; it is retried every cycle until it goes through.
// Ports   : clk_i, rst_ni            clock, async active-low reset
//           req_valid_i  [NReq]      per-requester update request
//           req_addr_i   [NReq*AW]   requester i index at [i*AW +: AW]
//           req_data_i   [NReq*DW]   requester i data  at [i*DW +: DW]
//           req_ready_o  [NReq]      accept, one-hot or zero
//           sw_we_i, sw_addr_i       software write strobe / index
//           de_o, de_addr_o, d_o     hardware write enable / index / data
//           busy_o                   output stage holds a pending update
//           conflict_cnt_o [8]       saturating count of deferred cycles
// Revision: 1.0 - initial release
// ============================================================================
module rv_iopmp_hw_wr_arb
   import rv_iopmp_pkg::*;
#(
   parameter int unsigned NReq = 4,
   parameter int unsigned DW   = RV_IOPMP_DW,
   parameter int unsigned AW   = RV_IOPMP_AW
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NReq-1:0]           req_valid_i,
   input  logic [NReq*AW-1:0]        req_addr_i,
   input  logic [NReq*DW-1:0]        req_data_i,
   output logic [NReq-1:0]           req_ready_o,
   input  logic                      sw_we_i,
   input  logic [AW-1:0]             sw_addr_i,
   output logic                      de_o,
   output logic [AW-1:0]             de_addr_o,
   output logic [DW-1:0]             d_o,
   output logic                      busy_o,
   output logic [CONFLICT_CNT_W-1:0] conflict_cnt_o
);

   localparam int unsigned IdxW = (NReq > 1) ? $clog2(NReq) : 1;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic                      stage_valid_q, stage_valid_d;
   logic [AW-1:0]             stage_addr_q,  stage_addr_d;
   logic [DW-1:0]             stage_data_q,  stage_data_d;
   logic [IdxW-1:0]           rr_ptr_q,      rr_ptr_d;
   logic [CONFLICT_CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

   // ------------------------------------------------------------------
   // Per-requester views of the flattened request buses
   // ------------------------------------------------------------------
   logic [AW-1:0] req_addr_arr [NReq];
   logic [DW-1:0] req_data_arr [NReq];

   for (genvar i = 0; i < int'(NReq); i++) begin : g_unpack
      assign req_addr_arr[i] = req_addr_i[i*AW +: AW];
      assign req_data_arr[i] = req_data_i[i*DW +: DW];
   end

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   logic [NReq-1:0] gnt;
   logic [IdxW-1:0] gnt_idx;
   logic            any_gnt;

   rv_iopmp_rr_arb #(
      .NReq (NReq),
      .IdxW (IdxW)
   ) u_rr_arb (
      .req_i     (req_valid_i),
      .rr_ptr_i  (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_gnt_o (any_gnt)
   );

   // ------------------------------------------------------------------
   // Stage control
   // ------------------------------------------------------------------
   logic sw_hit;
   logic fire;
   logic accept_ok;
   logic accept;

   // Software owns the slice on a same-index collision, so the staged
   // hardware update stays put and tries again next cycle.
   assign sw_hit    = sw_we_i && (sw_addr_i == stage_addr_q);
   assign fire      = stage_valid_q && !sw_hit;
   // The stage can take a new entry when empty or draining this cycle,
   // which gives one update per cycle in steady state.
   assign accept_ok = !stage_valid_q || fire;
   assign accept    = accept_ok && any_gnt;

   // Ready is held low combinationally while reset is asserted.
   assign req_ready_o = (rst_ni && accept_ok) ? gnt : '0;

   always_comb begin
      stage_valid_d  = stage_valid_q;
      stage_addr_d   = stage_addr_q;
      stage_data_d   = stage_data_q;
      rr_ptr_d       = rr_ptr_q;
      conflict_cnt_d = conflict_cnt_q;

      if (accept) begin
         stage_valid_d = 1'b1;
         stage_addr_d  = req_addr_arr[gnt_idx];
         stage_data_d  = req_data_arr[gnt_idx];
         rr_ptr_d      = (gnt_idx == IdxW'(NReq - 1)) ? '0 : (gnt_idx + 1'b1);
      end else if (fire) begin
         stage_valid_d = 1'b0;
      end

      if (stage_valid_q && sw_hit) begin
         conflict_cnt_d = sat_inc(conflict_cnt_q);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stage_valid_q  <= 1'b0;
         stage_addr_q   <= '0;
         stage_data_q   <= '0;
         rr_ptr_q       <= '0;
         conflict_cnt_q <= '0;
      end else begin
         stage_valid_q  <= stage_valid_d;
         stage_addr_q   <= stage_addr_d;
         stage_data_q   <= stage_data_d;
         rr_ptr_q       <= rr_ptr_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs (index/data read as zero whenever the stage is empty)
   // ------------------------------------------------------------------
   assign de_o           = fire;
   assign de_addr_o      = stage_valid_q ? stage_addr_q : '0;
   assign d_o            = stage_valid_q ? stage_data_q : '0;
   assign busy_o         = stage_valid_q;
   assign conflict_cnt_o = conflict_cnt_q;

endmodule : rv_iopmp_hw_wr_arb
`default_nettype wire

// File: tb/tb_rv_iopmp_hw_wr_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv_iopmp_hw_wr_arb
// Purpose : Self-checking bench for rv_iopmp_hw_wr_arb. A cycle reference
//           model predicts ready/de/busy/counter/pointer every cycle; each
//           accepted update is pushed to a scoreboard queue and popped when
//           the DUT writes it to the slice bank.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rv_iopmp_hw_wr_arb;
   import rv_iopmp_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = RV_IOPMP_AW;
   localparam int unsigned DW = RV_IOPMP_DW;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            sw_we;
   logic [AW-1:0]   sw_addr;
   logic            de;
   logic [AW-1:0]   de_addr;
   logic [DW-1:0]   d;
   logic            busy;
   logic [7:0]      conflict_cnt;

   rv_iopmp_hw_wr_arb #(.NReq(N), .DW(DW), .AW(AW)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .req_valid_i    (req_valid),
      .req_addr_i     (req_addr),
      .req_data_i     (req_data),
      .req_ready_o    (req_ready),
      .sw_we_i        (sw_we),
      .sw_addr_i      (sw_addr),
      .de_o           (de),
      .de_addr_o      (de_addr),
      .d_o            (d),
      .busy_o         (busy),
      .conflict_cnt_o (conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic          m_sv;
   int            m_ptr;
   int            m_cnt;
   hw_upd_t       sb_q[$];
   logic [N-1:0]  refill;
   int            de_pulses;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int i, input logic [AW-1:0] a, input logic [DW-1:0] dd);
      req_valid[i]          = 1'b1;
      req_addr[i*AW +: AW]  = a;
      req_data[i*DW +: DW]  = dd;
   endtask

   // One clock: check at the falling edge, advance the model, then let the
   // requesters react to acceptance just after the rising edge.
   task automatic cyc();
      int      g;
      logic    e_fire;
      logic    e_ok;
      logic [N-1:0] e_rdy;
      hw_upd_t u;
      @(negedge clk);
      g = -1;
      if (!rst_n) begin
         m_sv = 1'b0; m_ptr = 0; m_cnt = 0; sb_q.delete();
         chk("rst_ready", 64'(req_ready), 64'(0));
         chk("rst_de",    64'(de),        64'(0));
         chk("rst_busy",  64'(busy),      64'(0));
         chk("rst_addr",  64'(de_addr),   64'(0));
         chk("rst_data",  64'(d),         64'(0));
         chk("rst_cnt",   64'(conflict_cnt), 64'(0));
      end else begin
         e_fire = m_sv && !(sw_we && sb_q.size() > 0 && sw_addr == sb_q[0].addr);
         e_ok   = !m_sv || e_fire;
         for (int k = 0; k < int'(N); k++) begin
            int idx;
            idx = (m_ptr + k) % int'(N);
            if (g < 0 && req_valid[idx]) g = idx;
         end
         e_rdy = (e_ok && g >= 0) ? (N'(1) << g) : '0;
         chk("ready", 64'(req_ready), 64'(e_rdy));
         chk("de",    64'(de),        64'(e_fire));
         chk("busy",  64'(busy),      64'(m_sv));
         chk("cnt",   64'(conflict_cnt), 64'(m_cnt));
         chk("rr_ptr", 64'(dut.rr_ptr_q), 64'(m_ptr));
         if (m_sv) begin
            chk("de_addr", 64'(de_addr), 64'(sb_q[0].addr));
            chk("d",       64'(d),       64'(sb_q[0].data));
         end else begin
            chk("de_addr_idle", 64'(de_addr), 64'(0));
            chk("d_idle",       64'(d),       64'(0));
         end
         if (de) de_pulses++;
         if (m_sv && !e_fire && m_cnt < 255) m_cnt++;
         if (e_fire) begin
            void'(sb_q.pop_front());
            m_sv = 1'b0;
         end
         if (e_ok && g >= 0) begin
            u.addr = req_addr[g*AW +: AW];
            u.data = req_data[g*DW +: DW];
            sb_q.push_back(u);
            m_sv  = 1'b1;
            m_ptr = (g + 1) % int'(N);
         end else begin
            g = -1;
         end
      end
      @(posedge clk);
      #1;
      if (g >= 0) begin
         if (refill[g])
            drive(g, AW'($urandom_range(16, 63)), $urandom);
         else
            req_valid[g] = 1'b0;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
      sw_we = 1'b0; sw_addr = '0; refill = '0; de_pulses = 0;
      m_sv = 1'b0; m_ptr = 0; m_cnt = 0;

      // Reset with every requester asking: ready must stay low.
      req_valid = '1;
      run(2);
      req_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      run(2);

      // Single requester 2: accepted at T, written at T+1, pointer to 3.
      drive(2, 6'h05, 32'hDEAD_BEEF);
      run(3);
      chk("single_ptr", 64'(dut.rr_ptr_q), 64'(3));

      // All four continuously valid, starting from pointer 0.
      rst_n = 1'b0; run(1); @(posedge clk); #1; rst_n = 1'b1;
      refill = '1;
      for (int i = 0; i < int'(N); i++) drive(i, AW'(16 + i), 32'h1000_0000 + i);
      run(9);
      refill = '0;
      run(6);
      chk("stream_drained", 64'(busy), 64'(0));

      // Same-index software write defers the staged update for 3 cycles.
      drive(0, 6'h0A, 32'hA5A5_0001);
      run(1);
      drive(1, 6'h11, 32'h0000_1111);
      sw_we = 1'b1; sw_addr = 6'h0A;
      run(3);
      chk("conflict_cnt3", 64'(conflict_cnt), 64'(3));
      sw_we = 1'b0;
      run(3);

      // Different-index software write does not block.
      drive(0, 6'h0A, 32'hA5A5_0002);
      run(1);
      sw_we = 1'b1; sw_addr = 6'h0B;
      run(2);
      sw_we = 1'b0;
      chk("no_defer_cnt", 64'(conflict_cnt), 64'(3));

      // Saturation of the deferral counter.
      drive(3, 6'h0A, 32'h5A5A_0003);
      run(1);
      sw_we = 1'b1; sw_addr = 6'h0A;
      run(300);
      chk("sat_cnt", 64'(conflict_cnt), 64'(255));
      sw_we = 1'b0;
      run(2);

      // Reset while a staged entry is pending: it is discarded.
      drive(1, 6'h01, 32'h0BAD_F00D);
      run(1);
      chk("pre_rst_busy", 64'(busy), 64'(1));
      rst_n = 1'b0;
      run(2);
      @(posedge clk); #1;
      rst_n = 1'b1;
      de_pulses = 0;
      run(4);
      chk("post_rst_no_de", 64'(de_pulses), 64'(0));
      chk("post_rst_ptr",   64'(dut.rr_ptr_q), 64'(0));

      // Idle gap between requester 1 and requester 3.
      drive(1, 6'h21, 32'h1111_2222);
      run(2);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("gap_busy", 64'(busy), 64'(0));
         chk("gap_ptr",  64'(dut.rr_ptr_q), 64'(2));
      end
      drive(3, 6'h33, 32'h3333_4444);
      run(3);
      chk("gap_final_ptr", 64'(dut.rr_ptr_q), 64'(0));
      chk("sb_empty", 64'(sb_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_rv_iopmp_hw_wr_arb
`default_nettype wire
